multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: go  in  1  leave IDLE and start fetching; DATA  in  32  instruction register contents; start  in  1  condition-pass from flag unit.
REQ-004 SHALL have outputs, 1 bit each: PCWrite, MemAdr, MemWrite, MemRead, IRWrite, Opr2, RegDst, MemToReg, ALUSrcA, RegWrite, PCSrc, FlagWrite, Start_Flag.
REQ-005 SHALL have outputs: ALUSrcB  out  2; ALUOperation  out  3; busy  out  1 (state not IDLE/HALT); halted  out  1; retired  out  16 (instructions completed).
REQ-006 SHALL use this encoding: DATA[31:30] cond; [29:28] type (00 DP-reg, 01 DP-imm, 10 memory, 11 branch); [27:25] opcode; [20] S for DP, L for memory (1 load); [26] link for branch; 32'hFFFFFFFF is HALT.
REQ-007 SHALL use opcodes ADD 000, SUB 001, AND 010, ORR 011, MOV 100, MVN 101, CMP 110, TST 111.

Function
REQ-008 SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_RD, MEM_WB, MEM_WR, BRANCH, HALT; every control output not named for a state SHALL be 0.
REQ-009 IDLE: go=1 -> FETCH, else stay.
REQ-010 FETCH: MemAdr=1, MemRead=1, IRWrite=1, ALUSrcA=1, ALUSrcB=11, ALUOperation=ADD, PCSrc=1, PCWrite=1; -> DECODE.
REQ-011 DECODE: Start_Flag=1; Opr2=1 for DP-reg, else 0; DATA==FFFFFFFF -> HALT; start=0 -> FETCH with retired incremented; else by type -> EXEC_R, EXEC_I, MEM_RD (L=1), MEM_WR (L=0), BRANCH.
REQ-012 DECODE with branch, link=1, start=1: RegWrite=1, RegDst=0, MemToReg=0, writing the fetched PC+1 into R15.
REQ-013 EXEC_R: ALUSrcA=0, ALUSrcB=00, Opr2=1; EXEC_I: ALUSrcA=0, ALUSrcB=01; both drive the mapped ALUOperation.
REQ-014 Mapping: opcodes 000-101 pass through; CMP -> SUB, TST -> AND.
REQ-015 EXEC FlagWrite=1 if S=1 or opcode is CMP/TST; CMP/TST -> FETCH, all others -> ALU_WB.
REQ-016 ALU_WB: RegWrite=1, RegDst=1, MemToReg=0; -> FETCH.
REQ-017 MEM_RD: ALUSrcA=0, ALUSrcB=01, ADD, MemAdr=0, MemRead=1; -> MEM_WB.
REQ-018 MEM_WB: RegWrite=1, RegDst=1, MemToReg=1; -> FETCH.
REQ-019 MEM_WR: ALUSrcA=0, ALUSrcB=01, ADD, MemAdr=0, MemWrite=1, Opr2=0; -> FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=10, ADD, PCSrc=1, PCWrite=1; -> FETCH.
REQ-021 Latencies from FETCH to next FETCH: skipped 2, branch 3, DP/CMP 3-4, store 3, load 4 cycles.
REQ-022 retired SHALL increment by 1 on every transition into FETCH except from IDLE, wrap 16'hFFFF -> 0, and hold in HALT.
REQ-023 HALT: halted=1, busy=0; stays until reset; go ignored.
REQ-024 Outputs SHALL be decoded from registered state and DATA only, with start used solely for DECODE branching and link write.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE and retired=0 from any state, including mid-instruction; all controls 0, busy=0, halted=0 the following cycle.
REQ-026 rst_n=0 SHALL override a simultaneous go=1.

Structure
REQ-027 A shared package ctrl_pkg SHALL hold state enum, type codes, opcodes, ALUOperation codes and HALT word.
REQ-028 One combinational sub-module alu_decoder SHALL map opcode/S to ALUOperation, FlagWrite and no-writeback.

Verification
REQ-029 Reset, go=1, DATA=32'h0012_3004 (ADD reg, start=1): FETCH, DECODE, EXEC_R (ALUOperation=000, Opr2=1), ALU_WB (RegWrite=1); retired=1.
REQ-030 DATA=32'h1C10_0005 (CMP imm, S=1): EXEC_I ALUOperation=001, FlagWrite=1, no ALU_WB; 3-cycle instruction.
REQ-031 Load 32'h2010_1004 then store 32'h2000_1004: load 4 cycles with MemRead at MEM_RD and MemToReg=1 at MEM_WB; store MemWrite=1 single cycle.
REQ-032 BL 32'h3400_0010, start=1: RegWrite=1, RegDst=0 in DECODE, PCSrc=1/PCWrite=1 in BRANCH; with start=0: back to FETCH after DECODE, no write.
REQ-033 DATA=32'hFFFFFFFF -> HALT, halted=1, go pulses ignored; rst_n=0 during MEM_RD -> IDLE next cycle, retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, instruction
// field values, ALU operation codes and the HALT word.
package ctrl_pkg;

  // FSM state codes
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_ALU_WB = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WB = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  // Instruction type field DATA[29:28]
  localparam logic [1:0] TY_DPR = 2'b00;
  localparam logic [1:0] TY_DPI = 2'b01;
  localparam logic [1:0] TY_MEM = 2'b10;
  localparam logic [1:0] TY_BR  = 2'b11;

  // Data-processing opcodes DATA[27:25]
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_MVN = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_TST = 3'b111;

  // ALUOperation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;
  localparam logic [2:0] ALU_MVN = 3'b101;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_decoder.sv
// Maps a data-processing opcode and S bit to the ALU operation, the flag
// write enable and whether the result is discarded (compare/test forms).
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic       s,
  output logic [2:0] alu_op,
  output logic       flag_write,
  output logic       no_wb
);

  // CMP/TST reuse SUB/AND and only update flags
  always_comb begin
    alu_op = opcode;
    no_wb  = 1'b0;
    case (opcode)
      OP_CMP: begin alu_op = ALU_SUB; no_wb = 1'b1; end
      OP_TST: begin alu_op = ALU_AND; no_wb = 1'b1; end
      default: ;
    endcase
    flag_write = s | no_wb;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle instruction controller. Control outputs are decoded
// from the registered state and the instruction register; start (condition
// pass) only steers DECODE branching and the branch-link write.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [31:0] DATA,
  input  logic        start,
  output logic        PCWrite,
  output logic        MemAdr,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        IRWrite,
  output logic        Opr2,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        FlagWrite,
  output logic        Start_Flag,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOperation,
  output logic        busy,
  output logic        halted,
  output logic [15:0] retired
);

  logic [3:0] state, nxt;
  logic [1:0] ty;
  logic [2:0] opc;
  logic       sl, link, is_halt;
  logic [2:0] dp_aop;
  logic       dp_fw, dp_nowb;

  assign ty      = DATA[29:28];
  assign opc     = DATA[27:25];
  assign sl      = DATA[20];
  assign link    = DATA[26];
  assign is_halt = (DATA == HALT_WORD);

  alu_decoder u_alu_dec (
    .opcode    (opc),
    .s         (sl),
    .alu_op    (dp_aop),
    .flag_write(dp_fw),
    .no_wb     (dp_nowb)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_FETCH && state != S_IDLE) retired <= retired + 16'd1;
    end
  end

  // Next-state selection
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (go) nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (is_halt)     nxt = S_HALT;
        else if (!start) nxt = S_FETCH;
        else begin
          case (ty)
            TY_DPR:  nxt = S_EXEC_R;
            TY_DPI:  nxt = S_EXEC_I;
            TY_MEM:  nxt = sl ? S_MEM_RD : S_MEM_WR;
            default: nxt = S_BRANCH;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: nxt = dp_nowb ? S_FETCH : S_ALU_WB;
      S_MEM_RD: nxt = S_MEM_WB;
      S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH: nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // Control decode per state; anything not named stays 0
  always_comb begin
    PCWrite      = 1'b0;
    MemAdr       = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    Opr2         = 1'b0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    ALUSrcA      = 1'b0;
    RegWrite     = 1'b0;
    PCSrc        = 1'b0;
    FlagWrite    = 1'b0;
    Start_Flag   = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = ALU_ADD;
    case (state)
      S_FETCH: begin
        MemAdr  = 1'b1;
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b11;
        PCSrc   = 1'b1;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        Start_Flag = 1'b1;
        Opr2       = (ty == TY_DPR);
        // Branch-and-link saves the already-incremented PC into R15
        RegWrite   = (ty == TY_BR) && link && start && !is_halt;
      end
      S_EXEC_R: begin
        ALUSrcB      = 2'b00;
        Opr2         = 1'b1;
        ALUOperation = dp_aop;
        FlagWrite    = dp_fw;
      end
      S_EXEC_I: begin
        ALUSrcB      = 2'b01;
        ALUOperation = dp_aop;
        FlagWrite    = dp_fw;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_MEM_RD: begin
        ALUSrcB = 2'b01;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        ALUSrcB  = 2'b01;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        PCSrc   = 1'b1;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule
